// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the RV32I load/store port.
// Takes one request at a time on a valid/ready request channel. It performs a
// byte, half or word access on an internal word array. It returns load data
// or an error on a valid/ready response channel LATENCY cycles after acceptance.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake
//   req_we            1 = store, 0 = load
//   req_addr          byte address (word index = req_addr[31:2])
//   req_wdata         store data, byte/half taken from the low bits
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      loads only: zero-extend when 1, sign-extend when 0
//   rsp_valid/ready   response handshake
//   rsp_rdata         extended load data, 0 for stores and errors
//   rsp_err           misaligned, illegal size or out-of-range access
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WIDX_W = ADDR_W - 2;
  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W  = 4;

  localparam logic             LAT_ONE  = (LATENCY == 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  // Captured request
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic               cap_en_c;

  // Word array, not reset
  logic [DATA_W-1:0]  mem_q [DEPTH_WORDS];

  // Access operands and results
  logic               accept_c;
  logic               exec_c;
  logic               acc_we_c;
  logic [ADDR_W-1:0]  acc_addr_c;
  logic [DATA_W-1:0]  acc_wdata_c;
  logic [1:0]         acc_size_c;
  logic               acc_uns_c;
  logic [WIDX_W-1:0]  word_idx_c;
  logic [IDX_W-1:0]   mem_idx_c;
  logic               in_range_c;
  logic [DATA_W-1:0]  rd_word_c;
  logic [4:0]         byte_sh_c;
  logic [4:0]         half_sh_c;
  logic [7:0]         ld_byte_c;
  logic [15:0]        ld_half_c;
  logic               acc_err_c;
  logic [DATA_W-1:0]  wmask_c;
  logic [DATA_W-1:0]  wdata_rep_c;
  logic [DATA_W-1:0]  ld_data_c;
  logic [DATA_W-1:0]  wr_word_c;
  logic [DATA_W-1:0]  rsp_data_c;
  logic               mem_we_c;

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign accept_c = req_valid & req_ready_q;

  // The access executes on the edge that enters RESP. With LATENCY==1 that is
  // the acceptance edge itself, so the live request is used instead of the copy.
  assign exec_c = ((state_q == ST_IDLE) && accept_c && LAT_ONE) ||
                  ((state_q == ST_BUSY) && (cnt_q == CNT_W'(1)));

  // Operand source: live inputs while idle, captured copy afterwards
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we_c    = req_we;
      acc_addr_c  = req_addr;
      acc_wdata_c = req_wdata;
      acc_size_c  = req_size;
      acc_uns_c   = req_unsigned;
    end else begin
      acc_we_c    = we_q;
      acc_addr_c  = addr_q;
      acc_wdata_c = wdata_q;
      acc_size_c  = size_q;
      acc_uns_c   = uns_q;
    end
  end

  assign word_idx_c = acc_addr_c[ADDR_W-1:2];
  assign in_range_c = (word_idx_c < WIDX_W'(DEPTH_WORDS));
  assign mem_idx_c  = word_idx_c[IDX_W-1:0];
  assign rd_word_c  = mem_q[mem_idx_c];
  assign byte_sh_c  = {acc_addr_c[1:0], 3'b000};
  assign half_sh_c  = {acc_addr_c[1], 4'b0000};
  assign ld_byte_c  = 8'(rd_word_c >> byte_sh_c);
  assign ld_half_c  = 16'(rd_word_c >> half_sh_c);

  // Lane decode, alignment/size/range checks and load extension
  always_comb begin
    acc_err_c   = 1'b0;
    wmask_c     = '0;
    wdata_rep_c = '0;
    ld_data_c   = '0;
    case (acc_size_c)
      SZ_BYTE: begin
        wmask_c     = 32'h0000_00FF << byte_sh_c;
        wdata_rep_c = {4{acc_wdata_c[7:0]}};
        ld_data_c   = acc_uns_c ? {24'b0, ld_byte_c} : {{24{ld_byte_c[7]}}, ld_byte_c};
      end
      SZ_HALF: begin
        acc_err_c   = acc_addr_c[0];
        wmask_c     = 32'h0000_FFFF << half_sh_c;
        wdata_rep_c = {2{acc_wdata_c[15:0]}};
        ld_data_c   = acc_uns_c ? {16'b0, ld_half_c} : {{16{ld_half_c[15]}}, ld_half_c};
      end
      SZ_WORD: begin
        acc_err_c   = |acc_addr_c[1:0];
        wmask_c     = '1;
        wdata_rep_c = acc_wdata_c;
        ld_data_c   = rd_word_c;
      end
      default: acc_err_c = 1'b1;
    endcase
    if (!in_range_c) begin
      acc_err_c = 1'b1;
    end
  end

  assign wr_word_c  = (rd_word_c & ~wmask_c) | (wdata_rep_c & wmask_c);
  assign rsp_data_c = (acc_we_c || acc_err_c) ? '0 : ld_data_c;
  assign mem_we_c   = exec_c & acc_we_c & ~acc_err_c;

  // Array write port
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_idx_c] <= wr_word_c;
    end
  end

  // Request capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
    end else if (cap_en_c) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next state and registered outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cap_en_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (accept_c) begin
          cap_en_c    = 1'b1;
          req_ready_d = 1'b0;
          if (LAT_ONE) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // Response held until consumed; ready for a new request on the next edge
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (exec_c) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = rsp_data_c;
      rsp_err_d   = acc_err_c;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: three instances (LATENCY 2, 1, 7) checked
// against a byte-addressed reference memory with directed and random accesses.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n;

  logic [2:0]       req_valid;
  logic [2:0]       req_we;
  logic [2:0][31:0] req_addr;
  logic [2:0][31:0] req_wdata;
  logic [2:0][1:0]  req_size;
  logic [2:0]       req_unsigned;
  logic [2:0]       rsp_ready;
  wire  [2:0]       req_ready;
  wire  [2:0]       rsp_valid;
  wire  [2:0][31:0] rsp_rdata;
  wire  [2:0]       rsp_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] mref [3][4096];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
    .req_unsigned(req_unsigned[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
    .req_unsigned(req_unsigned[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(7)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_size(req_size[2]),
    .req_unsigned(req_unsigned[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 7;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference access on a byte array: returns expected err/rdata, applies stores
  task automatic ref_access(input int d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size,
                            input logic uns, output logic err, output logic [31:0] rd);
    int nb;
    int base;
    logic [31:0] v;
    err = 1'b0;
    rd  = 32'h0;
    nb  = 1 << size;
    if (size == 2'd3) err = 1'b1;
    if (size == 2'd1 && (addr % 2) != 0) err = 1'b1;
    if (size == 2'd2 && (addr % 4) != 0) err = 1'b1;
    if ((addr / 4) >= 1024) err = 1'b1;
    if (!err) begin
      base = int'(addr % 4096);
      if (we) begin
        for (int i = 0; i < nb; i++) mref[d][base + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mref[d][base + i];
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
        rd = v;
      end
    end
  endtask

  // One complete transaction with rsp_ready held high
  task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        input string tag, output logic oerr, output logic [31:0] ord,
                        output int acc);
    logic        eerr;
    logic [31:0] erd;
    int          k;
    ref_access(d, we, addr, wdata, size, uns, eerr, erd);
    k = 0;
    while (req_ready[d] !== 1'b1 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    req_valid[d]    = 1'b1;
    req_we[d]       = we;
    req_addr[d]     = addr;
    req_wdata[d]    = wdata;
    req_size[d]     = size;
    req_unsigned[d] = uns;
    rsp_ready[d]    = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    req_valid[d] = 1'b0;
    k = 1;
    while (rsp_valid[d] !== 1'b1 && k < 40) begin
      @(posedge clk); #1; k++;
    end
    chk({tag, " latency"}, 32'(k), 32'(lat_of(d)));
    oerr = rsp_err[d];
    ord  = rsp_rdata[d];
    chk({tag, " err"}, 32'(oerr), 32'(eerr));
    chk({tag, " rdata"}, ord, erd);
    @(posedge clk); #1;
    chk({tag, " rsp_valid drop"}, 32'(rsp_valid[d]), 32'h0);
    chk({tag, " req_ready back"}, 32'(req_ready[d]), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e;
    logic [31:0] r;
    int          a;
    int          prev;
    logic        eerr;
    logic [31:0] erd;
    int          k;

    rst_n        = 1'b0;
    req_valid    = '0;
    req_we       = '0;
    req_addr     = '0;
    req_wdata    = '0;
    req_size     = '0;
    req_unsigned = '0;
    rsp_ready    = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready[0]), 32'h0);
    chk("reset rsp_valid", 32'(rsp_valid[0]), 32'h0);
    chk("reset rsp_rdata", rsp_rdata[0], 32'h0);
    chk("reset rsp_err", 32'(rsp_err[0]), 32'h0);
    rst_n = 1'b1;
    chk("req_ready before first edge", 32'(req_ready[0]), 32'h0);
    @(posedge clk); #1;
    chk("req_ready after first edge", 32'({req_ready}), 32'h7);

    // Fill words 0..15 of every instance
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 16; w++) begin
        do_req(d, 1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, "init SW", e, r, a);
      end
    end
    do_req(0, 1'b1, 32'h20, 32'hAAAA_AAAA, 2'd2, 1'b0, "SW 0x20", e, r, a);
    do_req(0, 1'b1, 32'h00, 32'h0123_4567, 2'd2, 1'b0, "SW 0x00", e, r, a);

    // Word store/load
    do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, "SW 0x10", e, r, a);
    chk("SW 0x10 err const", 32'(e), 32'h0);
    chk("SW 0x10 rdata const", r, 32'h0);
    do_req(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, "LW 0x10", e, r, a);
    chk("LW 0x10 const", r, 32'hDEAD_BEEF);

    // Byte/half extension
    do_req(0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b0, "LB 0x13", e, r, a);
    chk("LB 0x13 const", r, 32'hFFFF_FFDE);
    do_req(0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b1, "LBU 0x13", e, r, a);
    chk("LBU 0x13 const", r, 32'h0000_00DE);
    do_req(0, 1'b0, 32'h12, 32'h0, 2'd1, 1'b0, "LH 0x12", e, r, a);
    chk("LH 0x12 const", r, 32'hFFFF_DEAD);
    do_req(0, 1'b0, 32'h10, 32'h0, 2'd1, 1'b1, "LHU 0x10", e, r, a);
    chk("LHU 0x10 const", r, 32'h0000_BEEF);
    do_req(0, 1'b1, 32'h11, 32'h55, 2'd0, 1'b0, "SB 0x11", e, r, a);
    do_req(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, "LW 0x10 after SB", e, r, a);
    chk("LW 0x10 after SB const", r, 32'hDEAD_55EF);

    // Errors
    do_req(0, 1'b0, 32'h01, 32'h0, 2'd1, 1'b0, "LH 0x01", e, r, a);
    chk("LH 0x01 err const", 32'(e), 32'h1);
    chk("LH 0x01 rdata const", r, 32'h0);
    do_req(0, 1'b1, 32'h02, 32'hFFFF_FFFF, 2'd2, 1'b0, "SW 0x02", e, r, a);
    chk("SW 0x02 err const", 32'(e), 32'h1);
    do_req(0, 1'b0, 32'h00, 32'h0, 2'd2, 1'b0, "LW 0x00", e, r, a);
    chk("LW 0x00 unchanged const", r, 32'h0123_4567);
    do_req(0, 1'b0, 32'h04, 32'h0, 2'd3, 1'b0, "size 11", e, r, a);
    chk("size 11 err const", 32'(e), 32'h1);
    do_req(0, 1'b0, 32'h1000, 32'h0, 2'd2, 1'b0, "LW 4*DEPTH", e, r, a);
    chk("LW 4*DEPTH err const", 32'(e), 32'h1);
    do_req(0, 1'b0, 32'hFFC, 32'h0, 2'd2, 1'b0, "LW last word", e, r, a);
    chk("LW last word err const", 32'(e), 32'h0);

    // Backpressure: response held, new requests ignored
    ref_access(0, 1'b0, 32'h10, 32'h0, 2'd1, 1'b0, eerr, erd);
    rsp_ready[0]    = 1'b0;
    req_valid[0]    = 1'b1;
    req_we[0]       = 1'b0;
    req_addr[0]     = 32'h10;
    req_size[0]     = 2'd1;
    req_unsigned[0] = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    k = 1;
    while (rsp_valid[0] !== 1'b1 && k < 40) begin
      @(posedge clk); #1; k++;
    end
    chk("bp latency", 32'(k), 32'h2);
    for (int i = 0; i < 5; i++) begin
      req_valid[0] = (i % 2 == 0);
      req_we[0]    = 1'b1;
      req_addr[0]  = 32'h20;
      req_wdata[0] = 32'h5555_5555;
      req_size[0]  = 2'd2;
      @(posedge clk); #1;
      chk("bp rsp_valid held", 32'(rsp_valid[0]), 32'h1);
      chk("bp rdata held", rsp_rdata[0], erd);
      chk("bp err held", 32'(rsp_err[0]), 32'(eerr));
      chk("bp req_ready low", 32'(req_ready[0]), 32'h0);
    end
    req_valid[0] = 1'b0;
    req_we[0]    = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp release rsp_valid", 32'(rsp_valid[0]), 32'h0);
    chk("bp release req_ready", 32'(req_ready[0]), 32'h1);
    chk("bp release rdata cleared", rsp_rdata[0], 32'h0);
    @(posedge clk); #1;
    chk("bp nothing accepted", 32'(rsp_valid[0]), 32'h0);

    // Latency sweep: back-to-back loads, accept interval LATENCY+1
    for (int d = 1; d < 3; d++) begin
      prev = 0;
      for (int n = 0; n < 4; n++) begin
        do_req(d, 1'b0, 32'($urandom_range(0, 15) * 4), 32'h0, 2'd2, 1'b0, "sweep LW", e, r, a);
        if (n > 0) chk("sweep accept interval", 32'(a - prev), 32'(lat_of(d) + 1));
        prev = a;
      end
    end

    // Reset while BUSY on a store: the store is abandoned
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'h1234_5678;
    req_size[0]  = 2'd2;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    req_we[0]    = 1'b0;
    chk("busy req_ready low", 32'(req_ready[0]), 32'h0);
    chk("busy rsp_valid low", 32'(rsp_valid[0]), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("midrst req_ready", 32'(req_ready[0]), 32'h0);
    chk("midrst rsp_valid", 32'(rsp_valid[0]), 32'h0);
    chk("midrst rsp_rdata", rsp_rdata[0], 32'h0);
    chk("midrst rsp_err", 32'(rsp_err[0]), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst release req_ready", 32'(req_ready[0]), 32'h0);
    @(posedge clk); #1;
    chk("midrst req_ready one edge later", 32'(req_ready[0]), 32'h1);
    do_req(0, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, "LW 0x20 after reset", e, r, a);
    chk("LW 0x20 unchanged const", r, 32'hAAAA_AAAA);

    // Random mix against the reference model
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 40; n++) begin
        logic [31:0] ra;
        logic [1:0]  rs;
        int          widx;
        widx = $urandom_range(0, 15);
        if ($urandom_range(0, 15) == 0) widx = 1024 + $urandom_range(0, 3);
        ra = 32'(widx * 4 + $urandom_range(0, 3));
        rs = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        do_req(d, 1'($urandom_range(0, 1)), ra, $urandom, rs, 1'($urandom_range(0, 1)),
               "random", e, r, a);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the RV32I datapath's load/store port. It accepts one request at a time on a valid/ready request channel and performs RV32I byte, half or word access on an internal word array. After a fixed programmable latency it returns read data or an error on a valid/ready response channel. This is the memory-side counterpart the datapath core and its benches talk to once loads and stores leave the single-cycle model.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; word index = req_addr[31:2].
LATENCY, 2, cycles from request acceptance edge to rsp_valid high; legal range 1..15.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data; byte/half taken from low bits
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads only: 1 = zero-extend (LBU/LHU), 0 = sign-extend
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  misaligned, illegal size, or out-of-range access

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; req_ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; counter = 0.
  - Array contents are not reset.
  - req_ready rises on the first clk edge after rst_n deasserts.
- States:
  - IDLE: req_ready = 1. On req_valid & req_ready, capture we/addr/wdata/size/unsigned. Go to RESP if LATENCY==1; otherwise go to BUSY with counter = LATENCY-1.
  - BUSY: req_ready = 0. Decrement counter each cycle. On the edge where counter==1, execute the access and enter RESP.
  - RESP: rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready. On that handshake, clear all three outputs and go to IDLE.
- Latency and throughput:
  - rsp_valid is high exactly LATENCY cycles after the acceptance edge.
  - No request is accepted in the handshake cycle; the next acceptance is one cycle after the response handshake at earliest.
- Access execution (at entry to RESP):
  - Error conditions:
    - half with addr[0]=1;
    - word with addr[1:0]!=0;
    - size==11;
    - word index >= DEPTH_WORDS.
  - On any error: rsp_err = 1, rsp_rdata = 0, no array write.
  - Store:
    - byte writes lane addr[1:0] with wdata[7:0];
    - half writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0];
    - word writes all lanes;
    - other lanes unchanged; rsp_rdata = 0.
  - Load:
    - select lane(s) as for stores;
    - extend to 32 bits per req_unsigned;
    - word ignores req_unsigned.
  - The write and read happen at the same edge, so a load issued after a store's response always sees the stored data.
- Request inputs are ignored outside IDLE; the captured copy is used throughout.
- rsp_ready held high while in IDLE or BUSY has no effect.
- Reset mid-operation (BUSY or RESP): the request is abandoned; a pending store is not written.

Test Plan:
1. Word store/load, LATENCY=2: store 0xDEADBEEF to 0x10 -> rsp_valid 2 cycles after accept, rsp_err=0, rdata=0; then load word 0x10 -> rdata=0xDEADBEEF.
2. Byte/half extension: with word 0x10 = 0xDEADBEEF:
   - LB 0x13 -> 0xFFFFFFDE;
   - LBU 0x13 -> 0x000000DE;
   - LH 0x12 -> 0xFFFFDEAD;
   - LHU 0x10 -> 0x0000BEEF;
   - SB 0x11 data 0x55 then LW 0x10 -> 0xDEAD55EF.
3. Errors:
   - LH 0x01 -> rsp_err=1, rdata=0;
   - SW 0x02 -> rsp_err=1 and a subsequent LW 0x00 shows unchanged data;
   - size=11 -> err;
   - addr 4*DEPTH_WORDS -> err.
4. Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata/err stable, req_ready=0, req_valid pulses ignored; release -> handshake, req_ready=1 next cycle.
5. Latency sweep LATENCY=1 and LATENCY=7: back-to-back loads with rsp_ready=1 -> rsp_valid exactly LATENCY cycles after each accept, one accept per LATENCY+1 cycles.
6. Reset mid-BUSY during SW 0x20 data 0x12345678 (word previously 0xAAAAAAAA) -> outputs 0 immediately; after release req_ready=1 one edge later; LW 0x20 -> 0xAAAAAAAA.
